fp_addsub_execute: RTL

FP_ADDSUB_EXECUTE -- requirements
Module: fp_addsub_execute

---
 rtl/fp_addsub_pkg.sv | 22 ++
 rtl/fp_addsub_shifter.sv | 31 +++
 rtl/fp_addsub_execute.sv | 102 ++++++++++
 3 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and default widths for the FP add/sub execute stage.
package fp_addsub_pkg;

    localparam int unsigned DEF_EXP_W = 3;
    localparam int unsigned DEF_MAN_W = 4;
    localparam int unsigned GRD_W     = 3;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Align-stage payload; field widths follow the package defaults
    typedef struct packed {
        op_e                            op;
        logic [DEF_EXP_W-1:0]           cexp;
        logic [DEF_MAN_W-1:0]           mmax;
        logic [DEF_MAN_W+GRD_W-1:0]     ext;
        logic                           sticky;
    } s1_payload_t;

endpackage

// File: rtl/fp_addsub_shifter.sv
// Right-shifts the smaller mantissa into guard positions and folds the
// shifted-out bits into a sticky flag.
module fp_addsub_shifter
    import fp_addsub_pkg::*;
#(
    parameter int unsigned MAN_W = DEF_MAN_W,
    parameter int unsigned EXP_W = DEF_EXP_W
) (
    input  logic [MAN_W-1:0]       mmin,
    input  logic [EXP_W-1:0]       shift,
    output logic [MAN_W+GRD_W-1:0] ext,
    output logic                   sticky
);

    localparam int unsigned EXT_W = MAN_W + GRD_W;

    logic [EXT_W-1:0] full;

    // Shifts at or beyond EXT_W naturally give ext=0 and sticky=|mmin
    always_comb begin
        full   = {mmin, GRD_W'(0)};
        ext    = full >> shift;
        sticky = 1'b0;
        for (int unsigned i = 0; i < EXT_W; i++) begin
            if (32'(shift) > i) begin
                sticky = sticky | full[i];
            end
        end
    end

endmodule

// File: rtl/fp_addsub_execute.sv
// Two-stage add/sub execute: S1 aligns the smaller mantissa, S2 adds or
// subtracts; valid/ready handshakes with one beat of storage per stage.
module fp_addsub_execute
    import fp_addsub_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned MAN_W = DEF_MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_op,
    input  logic [EXP_W-1:0]   in_cexp,
    input  logic [MAN_W-1:0]   in_mmax,
    input  logic [MAN_W-1:0]   in_mmin,
    input  logic [EXP_W-1:0]   in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_exp,
    output logic [2*MAN_W:0]   out_sum,
    output logic               out_zero
);

    localparam int unsigned EXT_W = MAN_W + GRD_W;
    localparam int unsigned SUM_W = 2 * MAN_W;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    s1_payload_t      s1_q;
    s1_payload_t      s1_d;
    logic [EXT_W-1:0] ext;
    logic             sticky;
    logic [SUM_W-1:0] opa;
    logic [SUM_W-1:0] opb;
    logic [SUM_W:0]   sum;

    fp_addsub_shifter #(
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_shifter (
        .mmin   (in_mmin),
        .shift  (in_shift),
        .ext    (ext),
        .sticky (sticky)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        s1_d        = '0;
        s1_d.op     = op_e'(in_op);
        s1_d.cexp   = DEF_EXP_W'(in_cexp);
        s1_d.mmax   = DEF_MAN_W'(in_mmax);
        s1_d.ext    = (DEF_MAN_W + GRD_W)'(ext);
        s1_d.sticky = sticky;
    end

    // Subtract wraps modulo 2^SUM_W with the carry bit forced low
    always_comb begin
        opa = SUM_W'({s1_q.mmax, MAN_W'(0)});
        opb = SUM_W'({s1_q.ext, s1_q.sticky});
        if (s1_q.op == OP_SUB) begin
            sum = {1'b0, opa - opb};
        end else begin
            sum = (SUM_W + 1)'(opa) + (SUM_W + 1)'(opb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            out_exp  <= '0;
            out_sum  <= '0;
            out_zero <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            // Output registers only move when S2 advances, so a stalled beat holds
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_exp  <= EXP_W'(s1_q.cexp);
                    out_sum  <= sum;
                    out_zero <= (sum == '0);
                end
            end
        end
    end

endmodule
